// File: rtl/axi_llc_pkg.sv
// Shared LLC tag BIST types: tag pattern layout, index/way types and the tracked read request.
// MaxRamLatency bounds the checker's request-to-data delay pipeline.
package axi_llc_pkg;

    localparam int unsigned PkgWays         = 32'd4;
    localparam int unsigned PkgPatternWidth = 32'd22;
    localparam int unsigned PkgIndexLength  = 32'd8;
    localparam int unsigned MaxRamLatency   = 32'd4;

    typedef struct packed {
        logic                       val;
        logic                       dit;
        logic [PkgPatternWidth-3:0] tag;
    } pattern_t;

    typedef logic [PkgWays-1:0]        way_ind_t;
    typedef logic [PkgIndexLength-1:0] index_t;

    typedef struct packed {
        logic     valid;
        index_t   index;
        pattern_t pattern;
    } tag_req_t;

endpackage

// File: rtl/axi_llc_tag_bist_delay.sv
// RamLatency-deep shift pipeline for tracked tag reads; advances every cycle, no stall.
// Reset clears every stage so in-flight reads are dropped.
module axi_llc_tag_bist_delay
    import axi_llc_pkg::*;
#(
    parameter int unsigned RamLatency = 32'd1,
    parameter type         req_t      = tag_req_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  req_t req_i,
    output req_t req_o
);

    req_t r_stage [RamLatency];

    // Shift register: stage 0 takes the new request, each later stage takes its predecessor.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(RamLatency); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= req_i;
            for (int i = 1; i < int'(RamLatency); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign req_o = r_stage[RamLatency-1];

endmodule

// File: rtl/axi_llc_tag_bist_check.sv
// LLC tag BIST checker: compares delayed expected patterns against tag SRAM read data per way.
// Optional first-failure index log enabled by defining AXI_LLC_TAG_BIST_FAIL_LOG_EN.
module axi_llc_tag_bist_check
    import axi_llc_pkg::*;
#(
    parameter int unsigned SetAssociativity = 32'd4,
    parameter int unsigned PatternWidth     = 32'd22,
    parameter int unsigned IndexLength      = 32'd8,
    parameter int unsigned RamLatency       = 32'd1,
    parameter int unsigned CntWidth         = 32'd8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   req_i,
    input  logic                                   we_i,
    input  logic [IndexLength-1:0]                 index_i,
    input  logic [PatternWidth-1:0]                pattern_i,
    input  logic [SetAssociativity*PatternWidth-1:0] rdata_i,
    input  logic                                   clear_i,
    output logic [SetAssociativity-1:0]            bist_res_o,
    output logic                                   bist_res_valid_o,
    output logic [SetAssociativity*CntWidth-1:0]   err_cnt_o,
    output logic [IndexLength-1:0]                 fail_index_o,
    output logic                                   fail_valid_o
);

    if ((RamLatency < 32'd1) || (RamLatency > MaxRamLatency)) begin : g_bad_latency
        $error("axi_llc_tag_bist_check: RamLatency out of range");
    end

    typedef struct packed {
        logic                    valid;
        logic [IndexLength-1:0]  index;
        logic [PatternWidth-1:0] pattern;
    } req_t;

    logic                        w_read;
    req_t                        w_push;
    req_t                        w_tail;
    logic [SetAssociativity-1:0] w_match;
    logic [SetAssociativity-1:0] w_fail;

    logic [SetAssociativity-1:0] r_res;
    logic                        r_res_valid;
    logic [CntWidth-1:0]         r_cnt [SetAssociativity];

    assign w_read = req_i & ~we_i;

    // Payload is zeroed on non-read cycles so idle X never enters the pipeline.
    always_comb begin
        w_push.valid   = w_read;
        w_push.index   = '0;
        w_push.pattern = '0;
        if (w_read) begin
            w_push.index   = index_i;
            w_push.pattern = pattern_i;
        end else begin
            w_push.index   = '0;
            w_push.pattern = '0;
        end
    end

    axi_llc_tag_bist_delay #(
        .RamLatency (RamLatency),
        .req_t      (req_t)
    ) u_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (w_push),
        .req_o (w_tail)
    );

    // Per-way compare; a failure only counts when the pipeline tail holds a read.
    always_comb begin
        w_match = '0;
        w_fail  = '0;
        for (int w = 0; w < int'(SetAssociativity); w++) begin
            w_match[w] = (rdata_i[w*PatternWidth +: PatternWidth] == w_tail.pattern);
            w_fail[w]  = w_tail.valid & ~w_match[w];
        end
    end

    // Registered result; invalid cycles report all ways matched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_res       <= '1;
            r_res_valid <= 1'b0;
        end else if (w_tail.valid) begin
            r_res       <= w_match;
            r_res_valid <= 1'b1;
        end else begin
            r_res       <= '1;
            r_res_valid <= 1'b0;
        end
    end

    // Saturating per-way mismatch counters; clear overrides a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < int'(SetAssociativity); w++) begin
                r_cnt[w] <= '0;
            end
        end else if (clear_i) begin
            for (int w = 0; w < int'(SetAssociativity); w++) begin
                r_cnt[w] <= '0;
            end
        end else begin
            for (int w = 0; w < int'(SetAssociativity); w++) begin
                if (w_fail[w] && (r_cnt[w] != {CntWidth{1'b1}})) begin
                    r_cnt[w] <= r_cnt[w] + CntWidth'(1);
                end
            end
        end
    end

    // Flatten counters onto the status bus.
    always_comb begin
        err_cnt_o = '0;
        for (int w = 0; w < int'(SetAssociativity); w++) begin
            err_cnt_o[w*CntWidth +: CntWidth] = r_cnt[w];
        end
    end

    assign bist_res_o       = r_res;
    assign bist_res_valid_o = r_res_valid;

`ifdef AXI_LLC_TAG_BIST_FAIL_LOG_EN
    logic [IndexLength-1:0] r_fail_index;
    logic                   r_fail_valid;

    // First-failure log: sticky until clear or reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fail_index <= '0;
            r_fail_valid <= 1'b0;
        end else if (clear_i) begin
            r_fail_index <= '0;
            r_fail_valid <= 1'b0;
        end else if ((|w_fail) && !r_fail_valid) begin
            r_fail_index <= w_tail.index;
            r_fail_valid <= 1'b1;
        end else begin
            r_fail_index <= r_fail_index;
            r_fail_valid <= r_fail_valid;
        end
    end

    assign fail_index_o = r_fail_index;
    assign fail_valid_o = r_fail_valid;
`else
    assign fail_index_o = '0;
    assign fail_valid_o = 1'b0;
`endif

endmodule
